// File: rtl/spice_node_pkg.sv
// spice_node_pkg: shared FSM state type and fixed-point helpers for the
// analog node integrator bank (spice_node_cell / spice_node_bank).
package spice_node_pkg;

    // Sequencer phase states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } node_state_e;

    // Wide signed scratch type so that rail and tolerance comparisons never
    // overflow regardless of the node word width.
    localparam int CALC_W = 64;
    typedef logic signed [CALC_W-1:0] calc_t;

    // Saturating clamp of x into [lo, hi].
    function automatic calc_t sat_clamp(input calc_t x, input calc_t lo, input calc_t hi);
        calc_t r;
        if (x > hi) begin
            r = hi;
        end else if (x < lo) begin
            r = lo;
        end else begin
            r = x;
        end
        return r;
    endfunction

    // True when |x| <= tol.
    function automatic logic abs_within(input calc_t x, input calc_t tol);
        return (x <= tol) && (x >= -tol);
    endfunction

endpackage

// File: rtl/spice_node_cell.sv
// spice_node_cell: one analog node. Integrates the scaled branch current into
// a rail-clamped signed voltage, counts consecutive quiet updates and derives
// the digital level. SPICE_NODE_HYST_EN selects a hysteresis comparator for
// the digital level instead of the plain sign test.
module spice_node_cell
    import spice_node_pkg::*;
#(
    parameter int W             = 16,
    parameter int SHIFT         = 2,
    parameter int VHI           = 2**(W-2),
    parameter int VLO           = -(2**(W-2)),
    parameter int TOL           = 1,
    parameter int SETTLE_CYCLES = 3
`ifdef SPICE_NODE_HYST_EN
    ,
    parameter int VTH           = 2**(W-4)
`endif
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         update_i,
    input  logic [W-1:0] cur_i,
    output logic [W-1:0] v_o,
    output logic         p_o,
    output logic         settled_o
);

    localparam int QW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [QW-1:0] QMAX = QW'(SETTLE_CYCLES);

    logic signed [W-1:0] v_q, v_d;
    logic signed [W-1:0] vNext;
    logic signed [W:0]   inc;
    logic signed [W:0]   dv;
    logic signed [W+1:0] sum;
    logic                quiet;
    logic [QW-1:0]       quiet_q, quiet_d;
    logic                p_q, p_d;

    // Scale the current, add it to the voltage, clamp to the rails and measure the step.
    always_comb begin
        inc   = $signed({cur_i[W-1], cur_i}) >>> SHIFT;
        sum   = $signed({v_q[W-1], v_q[W-1], v_q}) + $signed({inc[W], inc});
        vNext = W'(sat_clamp(calc_t'(sum), calc_t'(VLO), calc_t'(VHI)));
        dv    = $signed({vNext[W-1], vNext}) - $signed({v_q[W-1], v_q});
        quiet = abs_within(calc_t'(dv), calc_t'(TOL));
    end

    // Commit the update only while running; the quiet run length restarts on any large step.
    always_comb begin
        v_d     = v_q;
        quiet_d = quiet_q;
        if (clear_i) begin
            quiet_d = '0;
        end else if (update_i) begin
            v_d = vNext;
            if (quiet) begin
                quiet_d = (quiet_q == QMAX) ? quiet_q : quiet_q + QW'(1);
            end else begin
                quiet_d = '0;
            end
        end
        settled_o = (quiet_d == QMAX);
    end

`ifdef SPICE_NODE_HYST_EN
    localparam logic signed [W-1:0] VTH_POS = W'(VTH);
    localparam logic signed [W-1:0] VTH_NEG = W'(-VTH);

    // Hysteresis comparator: set above +VTH, clear below -VTH, hold in between.
    always_comb begin
        p_d = p_q;
        if (v_q >= VTH_POS) begin
            p_d = 1'b1;
        end else if (v_q <= VTH_NEG) begin
            p_d = 1'b0;
        end
    end
`else
    // Plain sign comparator: the node reads high whenever its voltage is non-negative.
    always_comb begin
        p_d = ~v_q[W-1];
    end
`endif

    // Voltage, quiet counter and digital level registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q     <= W'(VLO);
            quiet_q <= '0;
            p_q     <= 1'b0;
        end else begin
            v_q     <= v_d;
            quiet_q <= quiet_d;
            p_q     <= p_d;
        end
    end

    assign v_o = v_q;
    assign p_o = p_q;

endmodule

// File: rtl/spice_node_bank.sv
// spice_node_bank: NCH analog node integrators sharing one settling-phase
// sequencer. A start request runs updates until every node has been quiet for
// SETTLE_CYCLES consecutive updates or the MAX_ITER budget is spent, then
// pulses done with timeout qualifying the outcome. Defining SPICE_NODE_HYST_EN
// gives each node a hysteresis comparator of half-band VTH.
module spice_node_bank
    import spice_node_pkg::*;
#(
    parameter int W             = 16,
    parameter int NCH           = 8,
    parameter int SHIFT         = 2,
    parameter int VHI           = 2**(W-2),
    parameter int VLO           = -(2**(W-2)),
    parameter int TOL           = 1,
    parameter int SETTLE_CYCLES = 3,
    parameter int MAX_ITER      = 64,
    parameter int VTH           = 2**(W-4)
) (
    input  logic                              eclk,
    input  logic                              ereset_n,
    input  logic                              start,
    input  logic [NCH*W-1:0]                  i,
    output logic [NCH*W-1:0]                  v,
    output logic [NCH-1:0]                    p,
    output logic                              busy,
    output logic                              done,
    output logic                              timeout,
    output logic [$clog2(MAX_ITER+1)-1:0]     iter
);

    localparam int IW = $clog2(MAX_ITER + 1);

    // Rails must be ordered and the hysteresis band non-negative.
    if (VHI <= VLO || VTH < 0) begin : g_bad_params
        $error("spice_node_bank: inconsistent rail/threshold parameters");
    end

    node_state_e     state_q, state_d;
    logic [IW-1:0]   iter_q, iter_d;
    logic            timeout_q, timeout_d;
    logic            phaseStart;
    logic            update;
    logic            allSettled;
    logic [NCH-1:0]  settled;

    assign phaseStart = (state_q == IDLE) && start;
    assign update     = (state_q == RUN);
    assign allSettled = &settled;

    for (genvar k = 0; k < NCH; k++) begin : g_node
        spice_node_cell #(
            .W             (W),
            .SHIFT         (SHIFT),
            .VHI           (VHI),
            .VLO           (VLO),
            .TOL           (TOL),
            .SETTLE_CYCLES (SETTLE_CYCLES)
`ifdef SPICE_NODE_HYST_EN
            ,
            .VTH           (VTH)
`endif
        ) u_cell (
            .clk_i     (eclk),
            .rst_ni    (ereset_n),
            .clear_i   (phaseStart),
            .update_i  (update),
            .cur_i     (i[k*W +: W]),
            .v_o       (v[k*W +: W]),
            .p_o       (p[k]),
            .settled_o (settled[k])
        );
    end

    // Phase sequencing: settling is judged on the counts produced by the current update, and wins over budget exhaustion.
    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    iter_d    = '0;
                    timeout_d = 1'b0;
                end
            end
            RUN: begin
                iter_d = iter_q + IW'(1);
                if (allSettled) begin
                    state_d   = DONE;
                    timeout_d = 1'b0;
                end else if (iter_d == IW'(MAX_ITER)) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state, iteration count and outcome registers.
    always_ff @(posedge eclk or negedge ereset_n) begin
        if (!ereset_n) begin
            state_q   <= IDLE;
            iter_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign timeout = timeout_q;
    assign iter    = iter_q;

endmodule

// File: tb/tb_spice_node_bank.sv
// tb_spice_node_bank: directed phases with hand-computed results; a scoreboard
// queue holds the expected outcome of each phase and a monitor compares it
// whenever the bank pulses done. Honours SPICE_NODE_HYST_EN for p expectations.
module tb_spice_node_bank;

    localparam int W             = 16;
    localparam int NCH           = 4;
    localparam int SHIFT         = 2;
    localparam int TOL           = 1;
    localparam int SETTLE_CYCLES = 3;
    localparam int MAX_ITER      = 64;
    localparam int IW            = $clog2(MAX_ITER + 1);
    localparam int VLO           = -16384;
    localparam int VHI           = 16384;

    logic              eclk     = 1'b0;
    logic              ereset_n = 1'b0;
    logic              start    = 1'b0;
    logic [NCH*W-1:0]  i        = '0;
    logic [NCH*W-1:0]  v;
    logic [NCH-1:0]    p;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [IW-1:0]     iter;

    int compareCount  = 0;
    int mismatchCount = 0;

    typedef struct {
        int               phaseId;
        logic             expTimeout;
        int               expIter;
        logic [NCH*W-1:0] expV;
        logic [NCH-1:0]   expP;
    } phaseExp_t;

    phaseExp_t expQueue[$];

    spice_node_bank #(
        .W             (W),
        .NCH           (NCH),
        .SHIFT         (SHIFT),
        .TOL           (TOL),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .MAX_ITER      (MAX_ITER)
    ) dut (
        .eclk     (eclk),
        .ereset_n (ereset_n),
        .start    (start),
        .i        (i),
        .v        (v),
        .p        (p),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .iter     (iter)
    );

    always #5 eclk = ~eclk;

    function automatic logic [NCH*W-1:0] packWords(input int a, input int b, input int c, input int d);
        logic [NCH*W-1:0] r;
        r[0*W +: W] = W'(a);
        r[1*W +: W] = W'(b);
        r[2*W +: W] = W'(c);
        r[3*W +: W] = W'(d);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic signed [63:0] actual, input logic signed [63:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        for (int k = 0; k < NCH; k++) begin
            checkOutput($sformatf("%s_v%0d", tag, k), $signed(v[k*W +: W]), VLO);
            checkOutput($sformatf("%s_p%0d", tag, k), p[k], 0);
        end
        checkOutput($sformatf("%s_busy", tag), busy, 0);
        checkOutput($sformatf("%s_done", tag), done, 0);
        checkOutput($sformatf("%s_timeout", tag), timeout, 0);
        checkOutput($sformatf("%s_iter", tag), iter, 0);
    endtask

    task automatic waitIter(input int target);
        int n;
        n = 0;
        while (iter !== IW'(target) && n < 200) begin
            @(negedge eclk);
            n++;
        end
        if (iter !== IW'(target)) begin
            checkOutput($sformatf("wait_iter%0d", target), iter, target);
        end
    endtask

    task automatic applyStimulus(input int phaseId, input logic [NCH*W-1:0] cur,
                                 input logic expTimeout, input int expIter,
                                 input logic [NCH*W-1:0] expV, input logic [NCH-1:0] expP);
        phaseExp_t e;
        int waited;
        e.phaseId    = phaseId;
        e.expTimeout = expTimeout;
        e.expIter    = expIter;
        e.expV       = expV;
        e.expP       = expP;
        expQueue.push_back(e);
        @(negedge eclk);
        i     = cur;
        start = 1'b1;
        @(negedge eclk);
        start = 1'b0;
        checkOutput($sformatf("phase%0d_busy_start", phaseId), busy, 1);
        waited = 0;
        while (done !== 1'b1 && waited < 200) begin
            @(negedge eclk);
            waited++;
        end
        if (done !== 1'b1) begin
            checkOutput($sformatf("phase%0d_done_wait", phaseId), done, 1);
            expQueue.delete();
        end else begin
            checkOutput($sformatf("phase%0d_busy_at_done", phaseId), busy, 0);
        end
        @(negedge eclk);
        @(negedge eclk);
    endtask

    // Monitor: every done pulse consumes one expected phase outcome.
    initial begin : monitor
        phaseExp_t e;
        forever begin
            @(negedge eclk);
            if (ereset_n === 1'b1 && done === 1'b1) begin
                if (expQueue.size() == 0) begin
                    checkOutput("unexpected_done", done, 0);
                end else begin
                    e = expQueue.pop_front();
                    checkOutput($sformatf("phase%0d_timeout", e.phaseId), timeout, e.expTimeout);
                    checkOutput($sformatf("phase%0d_iter", e.phaseId), iter, e.expIter);
                    for (int k = 0; k < NCH; k++) begin
                        checkOutput($sformatf("phase%0d_v%0d", e.phaseId, k),
                                    $signed(v[k*W +: W]), $signed(e.expV[k*W +: W]));
                    end
                    @(negedge eclk);
                    checkOutput($sformatf("phase%0d_done_width", e.phaseId), done, 0);
                    for (int k = 0; k < NCH; k++) begin
                        checkOutput($sformatf("phase%0d_p%0d", e.phaseId, k), p[k], e.expP[k]);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: run did not complete, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [NCH-1:0] pAtZero;
`ifdef SPICE_NODE_HYST_EN
        pAtZero = 4'b0010;
`else
        pAtZero = 4'b0011;
`endif
        repeat (3) @(negedge eclk);
        ereset_n = 1'b1;
        @(negedge eclk);
        checkReset("reset");

        // All quiet: settles after SETTLE_CYCLES updates, voltages untouched.
        applyStimulus(1, packWords(0, 0, 0, 0), 1'b0, 3, packWords(VLO, VLO, VLO, VLO), 4'b0000);
        // Node 0 ramps by 100 per update until the budget runs out.
        applyStimulus(2, packWords(400, 0, 0, 0), 1'b1, 64, packWords(-9984, VLO, VLO, VLO), 4'b0000);
        // Node 1 driven hard: -8193, -2, 8189, 16380, clamp 16384, then three quiet updates.
        applyStimulus(3, packWords(0, 32767, 0, 0), 1'b0, 8, packWords(-9984, VHI, VLO, VLO), 4'b0010);
        // Already on the upper rail: settles immediately.
        applyStimulus(4, packWords(0, 32767, 0, 0), 1'b0, 3, packWords(-9984, VHI, VLO, VLO), 4'b0010);
        // Node 2 pushed below the lower rail stays pinned at VLO.
        applyStimulus(5, packWords(0, 0, -32768, 0), 1'b0, 3, packWords(-9984, VHI, VLO, VLO), 4'b0010);
        // Node 0 walks upward through zero towards the hysteresis threshold.
        applyStimulus(6, packWords(400, 0, 0, 0), 1'b1, 64, packWords(-3584, VHI, VLO, VLO), 4'b0010);
        applyStimulus(7, packWords(224, 0, 0, 0), 1'b1, 64, packWords(0, VHI, VLO, VLO), pAtZero);
        applyStimulus(8, packWords(256, 0, 0, 0), 1'b1, 64, packWords(4096, VHI, VLO, VLO), 4'b0011);

        // Start during RUN is ignored; reset mid-phase aborts without a done pulse.
        @(negedge eclk);
        i     = packWords(400, 0, 0, 0);
        start = 1'b1;
        @(negedge eclk);
        start = 1'b0;
        waitIter(5);
        start = 1'b1;
        @(negedge eclk);
        start = 1'b0;
        checkOutput("ignored_start_iter", iter, 6);
        checkOutput("ignored_start_busy", busy, 1);
        waitIter(10);
        ereset_n = 1'b0;
        #1;
        checkReset("midphase_reset");
        repeat (3) @(negedge eclk);
        ereset_n = 1'b1;
        repeat (10) @(negedge eclk);
        checkOutput("post_reset_busy", busy, 0);
        checkOutput("post_reset_iter", iter, 0);

        // Fresh phase after the abort starts from the reset voltages.
        applyStimulus(9, packWords(0, 0, 0, 0), 1'b0, 3, packWords(VLO, VLO, VLO, VLO), 4'b0000);

        checkOutput("scoreboard_drained", expQueue.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
